// File: rtl/frame_tx_stream_pkg.sv
// Shared constants and state encoding for the frame_tx_stream byte assembler.
// The CRC helper is only referenced when FRAME_TX_CRC16_EN is defined.
package frame_tx_pkg;

    localparam int HDR_BYTES = 7;
    localparam int CHK_BYTES = 2;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE = 3'd0;
    localparam state_t S_HDR  = 3'd1;
    localparam state_t S_PAY  = 3'd2;
    localparam state_t S_CSUM = 3'd3;
    localparam state_t S_DONE = 3'd4;

    // CRC-16/CCITT-FALSE, MSB-first, one byte at a time.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc ^ {b, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/frame_tx_stream_if.sv
// Byte stream towards the TX FIFO. A byte moves when wvalid & wready are both high
// at a clk edge; once wvalid rises, wdata/last hold until that handshake.
interface frame_tx_stream_if;
    logic [7:0] wdata;
    logic       wvalid;
    logic       wready;
    logic       last;

    modport master (output wdata, output wvalid, output last, input wready);
    modport slave  (input wdata, input wvalid, input last, output wready);
endinterface

// File: rtl/frame_chk16.sv
// Byte-wide check word: 16-bit additive sum, or CRC-16/CCITT-FALSE when
// FRAME_TX_CRC16_EN is defined. chk_nxt is the value after absorbing din.
module frame_chk16
    import frame_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  din,
    output logic [15:0] chk,
    output logic [15:0] chk_nxt
);

    logic [15:0] chk_q;
    logic [15:0] chk_d;
    logic [15:0] clr_val;

`ifdef FRAME_TX_CRC16_EN
    assign clr_val = CRC_INIT;
    assign chk_nxt = crc16_byte(chk_q, din);
`else
    assign clr_val = 16'h0000;
    assign chk_nxt = chk_q + {8'h00, din};
`endif

    always_comb begin
        chk_d = chk_q;
        if (clr) begin
            chk_d = clr_val;
        end else if (en) begin
            chk_d = chk_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chk_q <= clr_val;
        end else begin
            chk_q <= chk_d;
        end
    end

    assign chk = chk_q;

endmodule

// File: rtl/frame_tx_stream.sv
// Latches header + payload on start and streams header, payload and a 16-bit check
// word byte by byte. Check word type selected by FRAME_TX_CRC16_EN (default: sum).
module frame_tx_stream
    import frame_tx_pkg::*;
#(
    parameter int MAX_PAYLOAD = 42,
    parameter int CNT_W       = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     busy,
    input  logic [15:0]              i_dst,
    input  logic [15:0]              i_src,
    input  logic [15:0]              i_size,
    input  logic                     i_dir,
    input  logic [6:0]               i_type,
    input  logic [MAX_PAYLOAD*8-1:0] i_payload,
    frame_tx_stream_if.master        tx,
    output logic                     o_trunc,
    output logic                     done,
    output logic [2:0]               dbg_state
);

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]         len_q, len_d;
    logic [15:0]              dst_q, dst_d;
    logic [15:0]              src_q, src_d;
    logic [7:0]               dirtype_q, dirtype_d;
    logic [MAX_PAYLOAD*8-1:0] payload_q, payload_d;
    logic [7:0]               wdata_q, wdata_d;
    logic                     wvalid_q, wvalid_d;
    logic                     last_q, last_d;
    logic                     trunc_q, trunc_d;

    logic                     hs;
    logic                     chk_clr;
    logic                     chk_en;
    logic [15:0]              chk;
    logic [15:0]              chk_nxt;
    logic [CNT_W-1:0]         nxt_idx;
    logic [CNT_W-1:0]         len_in;
    logic [15:0]              len16;
    logic [7:0]               hdr_nxt;
    logic [7:0]               pay_nxt;

    frame_chk16 u_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (chk_clr),
        .en      (chk_en),
        .din     (wdata_q),
        .chk     (chk),
        .chk_nxt (chk_nxt)
    );

    assign hs      = wvalid_q & tx.wready;
    assign nxt_idx = idx_q + 1'b1;
    assign len_in  = (i_size > 16'(MAX_PAYLOAD)) ? CNT_W'(MAX_PAYLOAD) : CNT_W'(i_size);
    assign len16   = 16'(len_q);

    // Byte that follows the current one within the header / payload sections.
    always_comb begin
        case (nxt_idx[2:0])
            3'd1:    hdr_nxt = dst_q[15:8];
            3'd2:    hdr_nxt = src_q[7:0];
            3'd3:    hdr_nxt = src_q[15:8];
            3'd4:    hdr_nxt = len16[7:0];
            3'd5:    hdr_nxt = len16[15:8];
            3'd6:    hdr_nxt = dirtype_q;
            default: hdr_nxt = dst_q[7:0];
        endcase
        pay_nxt = 8'h00;
        for (int k = 0; k < MAX_PAYLOAD; k++) begin
            if (nxt_idx == CNT_W'(k)) begin
                pay_nxt = payload_q[8*k +: 8];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        dst_d     = dst_q;
        src_d     = src_q;
        dirtype_d = dirtype_q;
        payload_d = payload_q;
        wdata_d   = wdata_q;
        wvalid_d  = wvalid_q;
        last_d    = last_q;
        trunc_d   = 1'b0;
        chk_clr   = 1'b0;
        chk_en    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dst_d     = i_dst;
                    src_d     = i_src;
                    len_d     = len_in;
                    dirtype_d = {i_dir, i_type};
                    payload_d = i_payload;
                    trunc_d   = (i_size > 16'(MAX_PAYLOAD));
                    chk_clr   = 1'b1;
                    wdata_d   = i_dst[7:0];
                    wvalid_d  = 1'b1;
                    idx_d     = '0;
                    state_d   = S_HDR;
                end
            end
            S_HDR: begin
                if (hs) begin
                    chk_en = 1'b1;
                    if (idx_q == CNT_W'(HDR_BYTES - 1)) begin
                        idx_d = '0;
                        if (len_q != '0) begin
                            wdata_d = payload_q[7:0];
                            state_d = S_PAY;
                        end else begin
                            // Check word must include the byte being accepted now.
                            wdata_d = chk_nxt[15:8];
                            state_d = S_CSUM;
                        end
                    end else begin
                        idx_d   = nxt_idx;
                        wdata_d = hdr_nxt;
                    end
                end
            end
            S_PAY: begin
                if (hs) begin
                    chk_en = 1'b1;
                    if (idx_q == len_q - 1'b1) begin
                        idx_d   = '0;
                        wdata_d = chk_nxt[15:8];
                        state_d = S_CSUM;
                    end else begin
                        idx_d   = nxt_idx;
                        wdata_d = pay_nxt;
                    end
                end
            end
            S_CSUM: begin
                if (hs) begin
                    if (idx_q == CNT_W'(CHK_BYTES - 1)) begin
                        wdata_d  = 8'h00;
                        wvalid_d = 1'b0;
                        last_d   = 1'b0;
                        state_d  = S_DONE;
                    end else begin
                        idx_d   = nxt_idx;
                        wdata_d = chk[7:0];
                        last_d  = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d  = S_IDLE;
                wvalid_d = 1'b0;
                last_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            len_q     <= '0;
            dst_q     <= '0;
            src_q     <= '0;
            dirtype_q <= '0;
            payload_q <= '0;
            wdata_q   <= '0;
            wvalid_q  <= 1'b0;
            last_q    <= 1'b0;
            trunc_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            dst_q     <= dst_d;
            src_q     <= src_d;
            dirtype_q <= dirtype_d;
            payload_q <= payload_d;
            wdata_q   <= wdata_d;
            wvalid_q  <= wvalid_d;
            last_q    <= last_d;
            trunc_q   <= trunc_d;
        end
    end

    assign tx.wdata  = wdata_q;
    assign tx.wvalid = wvalid_q;
    assign tx.last   = last_q;
    assign busy      = (state_q == S_HDR) || (state_q == S_PAY) || (state_q == S_CSUM);
    assign done      = (state_q == S_DONE);
    assign o_trunc   = trunc_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_frame_tx_stream.sv
// Directed bench for frame_tx_stream: a 42-byte-capacity instance for the main
// frames and a 4-byte-capacity instance for truncation.
module tb_frame_tx_stream;
  import frame_tx_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start, start4;
  logic [15:0] i_dst, i_src, i_size, i_size4;
  logic        i_dir;
  logic [6:0]  i_type;
  logic [42*8-1:0] i_payload;
  logic [31:0] i_payload4;
  logic        busy, busy4, trunc, trunc4, done, done4;
  logic [2:0]  dbg, dbg4;
  logic        wready_drv;

  frame_tx_stream_if tx ();
  frame_tx_stream_if tx4 ();
  assign tx.wready  = wready_drv;
  assign tx4.wready = wready_drv;

  frame_tx_stream #(.MAX_PAYLOAD(42), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
    .i_dst(i_dst), .i_src(i_src), .i_size(i_size), .i_dir(i_dir), .i_type(i_type),
    .i_payload(i_payload), .tx(tx.master), .o_trunc(trunc), .done(done), .dbg_state(dbg)
  );

  frame_tx_stream #(.MAX_PAYLOAD(4), .CNT_W(3)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .busy(busy4),
    .i_dst(i_dst), .i_src(i_src), .i_size(i_size4), .i_dir(i_dir), .i_type(i_type),
    .i_payload(i_payload4), .tx(tx4.master), .o_trunc(trunc4), .done(done4), .dbg_state(dbg4)
  );

  // Monitor view of whichever instance is under test.
  logic sel4;
  wire [7:0] m_wdata  = sel4 ? tx4.wdata  : tx.wdata;
  wire       m_wvalid = sel4 ? tx4.wvalid : tx.wvalid;
  wire       m_last   = sel4 ? tx4.last   : tx.last;
  wire       m_busy   = sel4 ? busy4      : busy;
  wire       m_done   = sel4 ? done4      : done;
  wire       m_trunc  = sel4 ? trunc4     : trunc;
  wire [2:0] m_state  = sel4 ? dbg4       : dbg;

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_step(input logic [15:0] c_in, input logic [7:0] b);
    logic [15:0] c;
`ifdef FRAME_TX_CRC16_EN
    c = c_in ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
`else
    c = c_in + {8'h00, b};
`endif
    return c;
  endfunction

  function automatic logic [15:0] model_init();
`ifdef FRAME_TX_CRC16_EN
    return 16'hFFFF;
`else
    return 16'h0000;
`endif
  endfunction

  // Appends the check word over everything currently queued.
  task automatic push_check();
    logic [15:0] c;
    c = model_init();
    foreach (exp_q[i]) c = model_step(c, exp_q[i]);
    exp_q.push_back(c[15:8]);
    exp_q.push_back(c[7:0]);
  endtask

  task automatic build_exp(input int maxp, input logic [15:0] size, input logic [42*8-1:0] pl);
    logic [15:0] len;
    len = (size > 16'(maxp)) ? 16'(maxp) : size;
    exp_q = {};
    exp_q.push_back(i_dst[7:0]); exp_q.push_back(i_dst[15:8]);
    exp_q.push_back(i_src[7:0]); exp_q.push_back(i_src[15:8]);
    exp_q.push_back(len[7:0]);   exp_q.push_back(len[15:8]);
    exp_q.push_back({i_dir, i_type});
    for (int k = 0; k < int'(len); k++) exp_q.push_back(pl[8*k +: 8]);
    push_check();
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_basic();
    i_dst = 16'h1234; i_src = 16'hABCD; i_size = 16'd2; i_dir = 1'b1; i_type = 7'h05;
    i_payload = '0; i_payload[15:0] = 16'h2211;
  endtask

  task automatic basic_exp();
    exp_q = {8'h34, 8'h12, 8'hCD, 8'hAB, 8'h02, 8'h00, 8'h85, 8'h11, 8'h22};
`ifdef FRAME_TX_CRC16_EN
    push_check();
`else
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h78);
`endif
  endtask

  task automatic launch(input bit use4);
    @(negedge clk);
    sel4 = use4;
    wready_drv = 1'b1;
    if (use4) start4 = 1'b1; else start = 1'b1;
  endtask

  // Consumes the frame against exp_q; returns after the last byte's handshake cycle.
  task automatic collect(input string name, input bit stall, input bit poke,
                         input bit exp_trunc, output bit saw_pay);
    int nb = 0, it = 0, stall_run = 0;
    bit finished = 0, have_hold = 0, poked = 0;
    logic [7:0] hold_data;
    logic hold_last;
    saw_pay = 0;
    while (!finished && it < 300) begin
      @(negedge clk);
      start = 1'b0; start4 = 1'b0;
      if (stall) begin
        if (stall_run >= 5 || $urandom_range(0, 2) == 0) begin wready_drv = 1'b1; stall_run = 0; end
        else begin wready_drv = 1'b0; stall_run++; end
      end else wready_drv = 1'b1;
      if (it == 0) begin
        check_val({name, "_trunc_pulse"}, m_trunc, exp_trunc);
        check_val({name, "_busy"}, m_busy, 1);
        check_val({name, "_first_valid"}, m_wvalid, 1);
      end
      if (it == 1) check_val({name, "_trunc_drop"}, m_trunc, 0);
      if (m_state == S_PAY) saw_pay = 1;
      if (have_hold) begin
        check_val({name, "_stall_data"}, m_wdata, hold_data);
        check_val({name, "_stall_last"}, m_last, hold_last);
        have_hold = 0;
      end
      if (m_wvalid && !wready_drv) begin
        have_hold = 1; hold_data = m_wdata; hold_last = m_last;
      end
      if (m_wvalid && wready_drv) begin
        if (exp_q.size() == 0) check_val({name, "_extra_byte"}, m_wdata, 0);
        else begin
          check_val($sformatf("%s_byte%0d", name, nb), m_wdata, exp_q.pop_front());
          check_val($sformatf("%s_last%0d", name, nb), m_last, exp_q.size() == 0);
          nb++;
          if (exp_q.size() == 0) finished = 1;
        end
      end
      if (poke && nb == 3 && !poked) begin
        start = 1'b1; i_dst = 16'hFFFF; i_size = 16'd7; poked = 1;
      end
      it++;
    end
    check_val({name, "_complete"}, finished, 1);
    if (!stall) check_val({name, "_no_bubbles"}, it, nb);
  endtask

  // done pulse after the last handshake; a start in the DONE cycle is ignored.
  task automatic check_done(input string name);
    @(negedge clk);
    check_val({name, "_done"}, m_done, 1);
    check_val({name, "_busy_done"}, m_busy, 0);
    check_val({name, "_valid_done"}, m_wvalid, 0);
    if (sel4) start4 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start = 1'b0; start4 = 1'b0;
    check_val({name, "_done_drop"}, m_done, 0);
    check_val({name, "_idle_after"}, m_state, S_IDLE);
    check_val({name, "_no_restart"}, m_wvalid, 0);
  endtask

  // ---------------- main sequence ----------------
  bit sp;
  int n_hs;
  bit hit;

  initial begin
    rst_n = 1'b0; start = 0; start4 = 0; sel4 = 0; wready_drv = 0;
    i_dst = 0; i_src = 0; i_size = 0; i_size4 = 0; i_dir = 0; i_type = 0;
    i_payload = '0; i_payload4 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_wvalid", tx.wvalid, 0);
    check_val("rst_wdata", tx.wdata, 0);
    check_val("rst_last", tx.last, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_trunc", trunc, 0);
    check_val("rst_state", dbg, S_IDLE);
    check_val("rst4_wvalid", tx4.wvalid, 0);
    rst_n = 1'b1;

    // Basic frame, full throughput.
    set_basic(); basic_exp();
    launch(0);
    collect("basic", 0, 0, 0, sp);
    check_val("basic_pay_seen", sp, 1);
    check_done("basic");

    // Zero payload: PAY skipped, 9 bytes.
    i_dst = 0; i_src = 0; i_size = 0; i_dir = 0; i_type = 0; i_payload = '0;
    build_exp(42, 16'd0, i_payload);
`ifndef FRAME_TX_CRC16_EN
    check_val("zero_chk_model", {exp_q[7], exp_q[8]}, 16'h0000);
`endif
    check_val("zero_len", exp_q.size(), 9);
    launch(0);
    collect("zero", 0, 0, 0, sp);
    check_val("zero_pay_skipped", sp, 0);
    check_done("zero");

    // Backpressure with a start poke (and input change) while busy.
    set_basic(); basic_exp();
    launch(0);
    collect("bp", 1, 1, 0, sp);
    check_done("bp");

    // Truncation on the 4-byte instance.
    i_dst = 16'h0102; i_src = 16'h0304; i_size4 = 16'd10; i_dir = 1'b0; i_type = 7'h7F;
    i_payload4 = 32'h44332211;
    build_exp(4, 16'd10, {{(42*8-32){1'b0}}, i_payload4});
    check_val("trunc_exp_len", exp_q.size(), 13);
    check_val("trunc_hdr_len", {exp_q[5], exp_q[4]}, 16'h0004);
    launch(1);
    collect("trunc", 0, 0, 1, sp);
    check_done("trunc");
    sel4 = 1'b0;

    // Reset during the 4th payload byte (frame byte index 10).
    i_dst = 16'h5566; i_src = 16'h7788; i_size = 16'd6; i_dir = 1'b1; i_type = 7'h2A;
    i_payload = '0; i_payload[47:0] = 48'h060504030201;
    launch(0);
    n_hs = 0; hit = 0;
    for (int it = 0; it < 40 && !hit; it++) begin
      @(negedge clk);
      start = 1'b0;
      if (tx.wvalid) begin
        if (n_hs == 10) begin
          check_val("mid_byte", tx.wdata, 8'h04);
          rst_n = 1'b0; hit = 1;
        end else n_hs++;
      end
    end
    check_val("mid_reached", hit, 1);
    @(negedge clk);
    check_val("mid_rst_wvalid", tx.wvalid, 0);
    check_val("mid_rst_wdata", tx.wdata, 0);
    check_val("mid_rst_last", tx.last, 0);
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_done", done, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val($sformatf("mid_no_done%0d", i), done, 0);
    end

    // Recovery: a complete, correct frame afterwards.
    set_basic(); basic_exp();
    launch(0);
    collect("recover", 0, 0, 0, sp);
    check_done("recover");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/frame_tx_stream.md
Name: frame_tx_stream

Overview:
- Parametrised successor to the fixed 51-byte MHP frame assembler.
- Latches one header and payload on `start`, then streams the frame byte-by-byte on a valid/ready interface, with the payload length taken from `i_size`.
- Appends a 16-bit check word and flags the last byte.
- Sits between the MHP command logic and the UART/byte-link TX FIFO.

Parameters:
- MAX_PAYLOAD, 42: payload capacity in bytes; range 1..255.
- CNT_W, 8: width of the internal byte counter; must satisfy 2^CNT_W > MAX_PAYLOAD.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock, reset is synchronous and active-low.
- start  in  1  request to send; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until DONE.
- i_dst  in  16  destination address.
- i_src  in  16  source address.
- i_size  in  16  requested payload length in bytes.
- i_dir  in  1  direction bit.
- i_type  in  7  frame type.
- i_payload  in  MAX_PAYLOAD*8  payload; byte k = bits [8k+7:8k].
- o_wdata  out  8  output byte.
- o_wvalid  out  1  o_wdata valid.
- i_wready  in  1  sink accepts the byte when o_wvalid & i_wready.
- o_last  out  1  high with the final check byte.
- o_trunc  out  1  one-cycle pulse at accept when i_size > MAX_PAYLOAD.
- done  out  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Reset (rst_n low at a clk edge):
  - o_wvalid, o_last, o_trunc, done, busy = 0; o_wdata = 0x00.
  - State = IDLE; check accumulator and counter cleared.
  - Reset mid-frame aborts the frame with no done pulse.
- Frame byte order:
  - Header, 7 bytes: dst[7:0], dst[15:8], src[7:0], src[15:8], len[7:0], len[15:8], {dir, type[6:0]}.
  - Then payload bytes 0..len-1.
  - Then check word, MSB first, 2 bytes.
  - Total length = 9 + len.
- len = min(i_size, MAX_PAYLOAD). The header carries len, not i_size.
- Check word: 16-bit wrap-around sum of every header and payload byte, each zero-extended to 16 bits.
- States:
  - IDLE: on start, latch all inputs, clear the check word, present header byte 0 with o_wvalid=1 on the next cycle, go to HDR.
  - HDR: advance on each handshake. After header byte 6 is accepted, go to PAY if len>0, else CSUM.
  - PAY: advance on each handshake. After byte len-1 is accepted, go to CSUM.
  - CSUM: send check[15:8], then check[7:0] with o_last=1. When the last byte is accepted, go to DONE.
  - DONE: done=1 for one cycle, busy=0, go to IDLE. start is ignored in this cycle.
- Backpressure: while o_wvalid=1 and i_wready=0, hold o_wdata, o_last and internal state stable. Each byte is added to the check word exactly once, on its handshake.
- Throughput: one byte per clk while i_wready=1; no bubbles between sections.
- Latency: start accepted at edge N → first byte valid after edge N. done asserts the cycle after the final handshake.
- start while busy is ignored; inputs may change freely after acceptance.
- o_wdata is registered; o_wvalid never drops without a handshake, except on reset.

Optional Feature:
- Macro FRAME_TX_CRC16_EN.
  - Defined: the check word is CRC-16/CCITT-FALSE (poly 0x1021, init 0xFFFF, no reflection, no final xor) over the same bytes, updated one byte per handshake, combinational per byte.
  - Undefined: 16-bit additive sum.
- Frame format and timing are identical in both builds.

Decomposition:
- Package frame_tx_pkg:
  - State enum (IDLE, HDR, PAY, CSUM, DONE).
  - HDR_BYTES=7, CHK_BYTES=2.
  - CRC_POLY=16'h1021, CRC_INIT=16'hFFFF.
- Sub-module frame_chk16: byte-wide check-word update (sum or CRC selected by the macro), with clear and enable inputs.

Test Plan:
- Basic frame: dst=0x1234, src=0xABCD, size=2, dir=1, type=0x05, payload 0x11,0x22, i_wready=1 → bytes 34 12 CD AB 02 00 85 11 22 02 78; o_last only on 0x78; done one cycle later; 11 consecutive valid cycles.
- Zero payload: size=0, dst=src=0, type=0, dir=0 → 00 00 00 00 00 00 00 00 00 (9 bytes); PAY state skipped.
- Truncation: MAX_PAYLOAD=4, size=10 → o_trunc pulse; header len bytes 04 00; 13 bytes total.
- Backpressure: basic frame with i_wready toggling pseudo-randomly (0 for up to 5 cycles) → identical byte sequence and check 0x0278; o_wdata stable while stalled.
- Reset mid-frame: rst_n low during the 4th payload byte → all outputs 0 the next cycle, no done pulse; a following start sends a complete correct frame.
- FRAME_TX_CRC16_EN build: the basic frame's check word must match a software CRC-16/CCITT-FALSE over the 9 header+payload bytes; a start pulse during busy is ignored.
